// File: rtl/hier_cmd_driver_if.sv
// Command and response handshake bundle for hier_cmd_driver.
//
// Both ports use the same valid/ready rule. A transfer happens on a rising
// clk edge where valid and ready are both high. Once a sender raises valid,
// it holds valid and its payload steady until that transfer happens. A
// receiver may raise or lower ready on any cycle.
//
// The slave modport is the driver block: it receives commands and sends
// responses. The master modport is the system side.
interface hier_cmd_driver_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_data;
  logic [7:0]       cmd_aux;
  logic [1:0]       cmd_ctrl;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_result;
  logic [1:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output cmd_valid, cmd_data, cmd_aux, cmd_ctrl, cmd_tag,
    input  cmd_ready,
    input  rsp_valid, rsp_result, rsp_flags, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_aux, cmd_ctrl, cmd_tag,
    output cmd_ready,
    output rsp_valid, rsp_result, rsp_flags, rsp_tag,
    input  rsp_ready
  );
endinterface

// File: rtl/hier_cmd_driver.sv
// Command-side initiator for the registered two-stage shift/ALU datapath.
//
// The block accepts one tagged command at a time and drives it onto the
// datapath. One cycle later it captures the registered result and flags. It
// then pushes {result, flags, tag} into an in-order response FIFO.
//
// The FSM runs IDLE -> DRIVE -> CAPTURE -> IDLE, so it takes one command
// every three cycles.
//
// Optional feature: define HIER_CMD_CHECK_EN to add a reference model of the
// datapath. The model is checked against the captured result in CAPTURE and
// drives chk_mismatch and chk_err_count.
//
// dbg_state shows the FSM state: 0 = IDLE, 1 = DRIVE, 2 = CAPTURE.
module hier_cmd_driver #(
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hier_cmd_driver_if.slave     host,
  output logic [7:0]           dp_main_data,
  output logic [7:0]           dp_aux_data,
  output logic [1:0]           dp_control,
  input  logic [7:0]           dp_final_result,
  input  logic [1:0]           dp_status_flags,
  output logic                 busy,
  output logic [1:0]           dbg_state
`ifdef HIER_CMD_CHECK_EN
  ,
  output logic                 chk_mismatch,
  output logic [7:0]           chk_err_count
`endif
);

  localparam int AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(RSP_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [TAG_W-1:0] tag_q;

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [7:0]       res_mem  [RSP_DEPTH];
  logic [1:0]       flg_mem  [RSP_DEPTH];
  logic [TAG_W-1:0] tag_mem  [RSP_DEPTH];

  logic accept, push, pop, fifo_empty;

  // Handshake decode. Space is checked on the full count (pop ignored),
  // so a command is accepted only if its response is sure to fit.
  always_comb begin
    fifo_empty     = (count == '0);
    host.cmd_ready = (state == IDLE) && (count < DEPTH_C);
    accept         = host.cmd_valid && host.cmd_ready;
    push           = (state == CAPTURE);
    pop            = !fifo_empty && host.rsp_ready;
    busy           = (state != IDLE);
    dbg_state      = state;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic: one command every three cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DRIVE;
      DRIVE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath drive registers. They hold the last command between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_main_data <= 8'h00;
      dp_aux_data  <= 8'h00;
      dp_control   <= 2'b00;
      tag_q        <= '0;
    end else if (accept) begin
      dp_main_data <= host.cmd_data;
      dp_aux_data  <= host.cmd_aux;
      dp_control   <= host.cmd_ctrl;
      tag_q        <= host.cmd_tag;
    end
  end

  // FIFO pointers and occupancy. A push and a pop in the same cycle cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage. Contents are don't-care until written; the head is gated below.
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[wr_ptr] <= dp_final_result;
      flg_mem[wr_ptr] <= dp_status_flags;
      tag_mem[wr_ptr] <= tag_q;
    end
  end

  // Response head. Fields read zero when empty, so stale entries never show.
  always_comb begin
    host.rsp_valid  = !fifo_empty;
    host.rsp_result = fifo_empty ? 8'h00 : res_mem[rd_ptr];
    host.rsp_flags  = fifo_empty ? 2'b00 : flg_mem[rd_ptr];
    host.rsp_tag    = fifo_empty ? '0    : tag_mem[rd_ptr];
  end

`ifdef HIER_CMD_CHECK_EN
  // Reference datapath: returns {result, overflow, |data}.
  function automatic logic [9:0] dp_model(input logic [7:0] d,
                                          input logic [7:0] a,
                                          input logic [1:0] c);
    logic [7:0] s;
    logic [7:0] r;
    logic       ov;
    s  = 8'h00;
    r  = 8'h00;
    ov = 1'b0;
    case (c)
      2'b00: begin
        s  = {1'b0, d[7:1]};
        r  = s + a;
        ov = (r < s);
      end
      2'b01:   r = 8'h00 - a;
      2'b10: begin
        s = {d[6:0], 1'b0};
        r = s & a;
      end
      default: r = a;
    endcase
    return {r, ov, |d};
  endfunction

  logic [9:0] model_exp;

  // Compare the captured datapath outputs with the model. The flag is only
  // meaningful during CAPTURE.
  always_comb begin
    model_exp    = dp_model(dp_main_data, dp_aux_data, dp_control);
    chk_mismatch = (state == CAPTURE) &&
                   (model_exp != {dp_final_result, dp_status_flags});
  end

  // Saturating count of mismatches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   chk_err_count <= 8'h00;
    else if (chk_mismatch && chk_err_count != 8'hFF) chk_err_count <= chk_err_count + 8'h01;
  end
`endif

endmodule

// File: tb/tb_hier_cmd_driver.sv
// Directed bench for hier_cmd_driver. It includes a behavioural stand-in for
// the registered datapath. Response values are hand-computed constants.
module tb_hier_cmd_driver;

  localparam int TAG_W = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] dp_main_data, dp_aux_data;
  logic [1:0] dp_control;
  logic [7:0] dp_final_result;
  logic [1:0] dp_status_flags;
  logic       busy;
  logic [1:0] dbg_state;
  logic       force_zero;
`ifdef HIER_CMD_CHECK_EN
  logic       chk_mismatch;
  logic [7:0] chk_err_count;
`endif

  int n_vec;
  int n_err;

  hier_cmd_driver_if #(.TAG_W(TAG_W)) hif ();

  hier_cmd_driver #(.RSP_DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .host            (hif.slave),
    .dp_main_data    (dp_main_data),
    .dp_aux_data     (dp_aux_data),
    .dp_control      (dp_control),
    .dp_final_result (dp_final_result),
    .dp_status_flags (dp_status_flags),
    .busy            (busy),
    .dbg_state       (dbg_state)
`ifdef HIER_CMD_CHECK_EN
    ,
    .chk_mismatch    (chk_mismatch),
    .chk_err_count   (chk_err_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- datapath stand-in ----------------
  logic [7:0] st1, dp_nxt_res;
  logic       dp_nxt_ov;
  logic [7:0] dp_res_q;
  logic [1:0] dp_flg_q;

  always_comb begin
    st1        = 8'h00;
    dp_nxt_res = 8'h00;
    dp_nxt_ov  = 1'b0;
    if (dp_control == 2'b00) begin
      st1        = dp_main_data >> 1;
      dp_nxt_res = st1 + dp_aux_data;
      dp_nxt_ov  = ({1'b0, st1} + {1'b0, dp_aux_data}) > 9'd255;
    end else if (dp_control == 2'b01) begin
      dp_nxt_res = ~dp_aux_data + 8'h01;
    end else if (dp_control == 2'b10) begin
      st1        = dp_main_data << 1;
      dp_nxt_res = st1 & dp_aux_data;
    end else begin
      dp_nxt_res = dp_aux_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_res_q <= 8'h00;
      dp_flg_q <= 2'b00;
    end else begin
      dp_res_q <= dp_nxt_res;
      dp_flg_q <= {dp_nxt_ov, (dp_main_data != 8'h00)};
    end
  end

  assign dp_final_result = force_zero ? 8'h00 : dp_res_q;
  assign dp_status_flags = dp_flg_q;

  // ---------------- scoreboard ----------------
  logic [13:0] exp_q[$];   // {result, flags, tag}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns at accept edge + 1.
  task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic [7:0] a,
                       input logic [3:0] t);
    int n;
    n = 0;
    @(negedge clk);
    hif.cmd_valid = 1'b1;
    hif.cmd_ctrl  = c;
    hif.cmd_data  = d;
    hif.cmd_aux   = a;
    hif.cmd_tag   = t;
    while (!hif.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("issue_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    hif.cmd_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    int n;
    logic [13:0] e;
    n = 0;
    @(negedge clk);
    while (!hif.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"},  {31'd0, hif.rsp_valid}, 32'd1);
      check({tag, "_result"}, {24'd0, hif.rsp_result}, {24'd0, e[13:6]});
      check({tag, "_flags"},  {30'd0, hif.rsp_flags},  {30'd0, e[5:4]});
      check({tag, "_tag"},    {28'd0, hif.rsp_tag},    {28'd0, e[3:0]});
    end
    hif.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    hif.rsp_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    force_zero    = 1'b0;
    hif.cmd_valid = 1'b0;
    hif.cmd_ctrl  = 2'b00;
    hif.cmd_data  = 8'h00;
    hif.cmd_aux   = 8'h00;
    hif.cmd_tag   = '0;
    hif.rsp_ready = 1'b0;
    rst_n         = 1'b0;

    // Reset values while held in reset.
    repeat (3) tick();
    check("rst_rsp_valid",  {31'd0, hif.rsp_valid}, 32'd0);
    check("rst_rsp_result", {24'd0, hif.rsp_result}, 32'd0);
    check("rst_rsp_flags",  {30'd0, hif.rsp_flags}, 32'd0);
    check("rst_rsp_tag",    {28'd0, hif.rsp_tag}, 32'd0);
    check("rst_busy",       {31'd0, busy}, 32'd0);
    check("rst_state",      {30'd0, dbg_state}, 32'd0);
    check("rst_dp_main",    {24'd0, dp_main_data}, 32'd0);
    check("rst_dp_aux",     {24'd0, dp_aux_data}, 32'd0);
    check("rst_dp_ctrl",    {30'd0, dp_control}, 32'd0);
`ifdef HIER_CMD_CHECK_EN
    check("rst_chk_mm",     {31'd0, chk_mismatch}, 32'd0);
    check("rst_chk_cnt",    {24'd0, chk_err_count}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_cmd_ready",  {31'd0, hif.cmd_ready}, 32'd1);

    // ctrl 00: s=0x40, 0x40+0xF0=0x30 with carry -> flags 11.
    issue(2'b00, 8'h80, 8'hF0, 4'd3);
    exp_q.push_back({8'h30, 2'b11, 4'd3});
    check("v1_dp_main",  {24'd0, dp_main_data}, 32'h80);
    check("v1_dp_aux",   {24'd0, dp_aux_data}, 32'hF0);
    check("v1_dp_ctrl",  {30'd0, dp_control}, 32'd0);
    check("v1_busy",     {31'd0, busy}, 32'd1);
    check("v1_state_e0", {30'd0, dbg_state}, 32'd1);
    check("v1_cmd_rdy",  {31'd0, hif.cmd_ready}, 32'd0);
    tick();
    check("v1_valid_e1", {31'd0, hif.rsp_valid}, 32'd0);
    check("v1_state_e1", {30'd0, dbg_state}, 32'd2);
    tick();
    check("v1_valid_e2", {31'd0, hif.rsp_valid}, 32'd1);
    check("v1_busy_e2",  {31'd0, busy}, 32'd0);
    pop_check("v1");
    check("v1_empty",    {31'd0, hif.rsp_valid}, 32'd0);

    // ctrl 10: (0x81<<1)=0x02 & 0xFF -> 0x02, flags 01.
    // ctrl 01: 0-0x01 = 0xFF, data 0 -> flags 00.
    issue(2'b10, 8'h81, 8'hFF, 4'd5);
    exp_q.push_back({8'h02, 2'b01, 4'd5});
    issue(2'b01, 8'h00, 8'h01, 4'd6);
    exp_q.push_back({8'hFF, 2'b00, 4'd6});
    repeat (2) tick();
    pop_check("v2");
    pop_check("v3");

    // Backpressure: four responses fill the FIFO.
    issue(2'b11, 8'h00, 8'h11, 4'd0);  exp_q.push_back({8'h11, 2'b00, 4'd0});
    issue(2'b00, 8'h02, 8'h05, 4'd1);  exp_q.push_back({8'h06, 2'b01, 4'd1});
    issue(2'b01, 8'h10, 8'h00, 4'd2);  exp_q.push_back({8'h00, 2'b01, 4'd2});
    issue(2'b00, 8'hFF, 8'h81, 4'd3);  exp_q.push_back({8'h00, 2'b11, 4'd3});
    repeat (4) tick();
    check("bp_full_rdy",  {31'd0, hif.cmd_ready}, 32'd0);
    check("bp_full_idle", {30'd0, dbg_state}, 32'd0);
    check("bp_head_tag",  {28'd0, hif.rsp_tag}, 32'd0);
    exp_q.push_back({8'h06, 2'b01, 4'd4});
    // Fifth command waits for space. Its push lands on the same edge as the
    // pop of tag 3, so the count stays unchanged.
    fork
      issue(2'b10, 8'hC3, 8'h0F, 4'd4);
      begin
        pop_check("bp0");
        pop_check("bp1");
        pop_check("bp2");
        pop_check("bp3");
      end
    join
    check("bp_after_valid", {31'd0, hif.rsp_valid}, 32'd1);
    pop_check("bp4");
    check("bp_drained", {31'd0, hif.rsp_valid}, 32'd0);

    // Reset during CAPTURE with one entry queued.
    issue(2'b11, 8'h01, 8'h77, 4'd7);
    repeat (2) tick();
    check("mr_queued", {31'd0, hif.rsp_valid}, 32'd1);
    issue(2'b11, 8'h01, 8'h88, 4'd8);
    tick();
    check("mr_in_capture", {30'd0, dbg_state}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("mr_valid", {31'd0, hif.rsp_valid}, 32'd0);
    check("mr_state", {30'd0, dbg_state}, 32'd0);
    check("mr_busy",  {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    check("mr_no_rsp",  {31'd0, hif.rsp_valid}, 32'd0);
    check("mr_rsp_tag", {28'd0, hif.rsp_tag}, 32'd0);
    check("mr_cmd_rdy", {31'd0, hif.cmd_ready}, 32'd1);

`ifdef HIER_CMD_CHECK_EN
    // Corrupted datapath result: expect 0x5A, see 0x00.
    force_zero = 1'b1;
    issue(2'b11, 8'h00, 8'h5A, 4'd9);
    exp_q.push_back({8'h00, 2'b00, 4'd9});
    check("ck_mm_drive", {31'd0, chk_mismatch}, 32'd0);
    tick();
    check("ck_mm_capt",  {31'd0, chk_mismatch}, 32'd1);
    check("ck_cnt_capt", {24'd0, chk_err_count}, 32'd0);
    tick();
    force_zero = 1'b0;
    check("ck_mm_after", {31'd0, chk_mismatch}, 32'd0);
    check("ck_cnt",      {24'd0, chk_err_count}, 32'd1);
    pop_check("ck_rsp");
`endif

    if (exp_q.size() != 0) check("sb_leftover", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
